hazard_sched_unit: RTL and testbench
====================================

Name: hazard_sched_unit

Overview:
- Pipeline hazard controller for the 5-stage RV32 core (F/D/E/M/W). Sits beside the decode ControlUnit outputs and the E/M/W pipeline registers.
- Generates operand forwarding selects, load-use stalls, and branch/jump flushes.
- Sequences the iterative multi-cycle mul/div unit in E: issues its start pulse, holds the pipeline for a fixed latency, then releases it.

Parameters:
- MD_LATENCY, 32, cycles the mul/div unit needs from start pulse to valid result; legal range 2..255.
- CNT_W, $clog2(MD_LATENCY), width of the latency down-counter (derived, not overridden).

Ports:
- clk  in  1  core clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- Rs1D, Rs2D  in  5 each  source registers of the instruction in D
- Rs1E, Rs2E, RdE  in  5 each  sources/destination of the instruction in E
- RdM, RdW  in  5 each  destinations in M and W
- RegWriteM, RegWriteW  in  1 each  register-write enables in M and W
- ResultSrcE0  in  1  bit 0 of ResultSrcE; 1 = instruction in E is a load
- PCSrcE  in  1  taken branch or jump resolved in E
- MdReqE  in  1  instruction in E is a MUL/DIV/REM op
- ForwardAE, ForwardBE  out  2 each  00 register file, 10 from M, 01 from W
- StallF, StallD, StallE  out  1 each  hold the PC, the D register and the E register
- FlushD, FlushE, FlushM  out  1 each  insert a bubble into the D, E and M registers
- MdStart  out  1  one-cycle start pulse to the mul/div unit
- MdBusy  out  1  mul/div sequence in progress
- MdResultSelE  out  1  select mul/div result onto the E result bus

Behaviour:
- Reset (async assert, sync release): state IDLE, counter 0. All outputs 0 while reset is asserted and in the first cycle after release. Reset during RUN abandons the operation; no MdStart is re-issued.
- Forwarding (combinational), ForwardAE:
  - 10 if RegWriteM & RdM!=0 & RdM==Rs1E;
  - else 01 if RegWriteW & RdW!=0 & RdW==Rs1E;
  - else 00.
  - M has priority over W. ForwardBE is identical using Rs2E.
- Load-use (combinational): lwStall = ResultSrcE0 & RdE!=0 & (RdE==Rs1D | RdE==Rs2D).
- Mul/div FSM states:
  - IDLE: if MdReqE, then MdStart=1 for this cycle, load counter with MD_LATENCY-2, go to RUN.
  - RUN: if counter==0 go to DONE, else decrement the counter.
  - DONE: go to IDLE unconditionally; MdReqE is ignored here so the same instruction is never re-issued.
- mdStall = (IDLE & MdReqE) | RUN. This gives exactly MD_LATENCY stalled cycles, issue cycle included.
- MdBusy = mdStall. MdResultSelE = 1 only in DONE; in DONE the instruction advances normally.
- Output equations:
  - StallF = StallD = lwStall | mdStall
  - StallE = mdStall
  - FlushM = mdStall, so W sees bubbles and no duplicate write occurs.
  - FlushD = PCSrcE
  - FlushE = (lwStall | PCSrcE) & ~mdStall
- Simultaneous events:
  - PCSrcE and MdReqE are mutually exclusive by decode (one E instruction).
  - lwStall cannot arise during RUN (E holds a mul/div op), so mdStall dominates.
  - A back-to-back mul/div op entering E in the cycle after DONE issues normally from IDLE.
- RdE/Rd*=0 never forwards and never stalls.

Decomposition:
- Shared package hazard_pkg: FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10, the md_state_t enum {IDLE, RUN, DONE}, and the RESULTSRC_LOAD constant.
- Natural sub-module: md_sequencer (FSM + counter → MdStart, MdBusy, MdResultSelE, mdStall). The top level holds the forwarding and stall/flush logic.

Test Plan:
- Forwarding: RegWriteM=1, RdM=5, Rs1E=5, RegWriteW=1, RdW=5 → ForwardAE=10. Drop RegWriteM → 01. Set RdM=RdW=0 → 00.
- Load-use: ResultSrcE0=1, RdE=7, Rs2D=7 → StallF=StallD=FlushE=1, StallE=0. RdE=0 → all 0.
- Branch: PCSrcE=1, no other hazards → FlushD=FlushE=1, no stalls.
- Mul/div, MD_LATENCY=4: MdReqE held from cycle 0.
  - MdStart=1 only in cycle 0.
  - StallF/D/E=FlushM=MdBusy=1 in cycles 0-3, FlushE=0.
  - Cycle 4: MdResultSelE=1, all stalls 0.
  - Cycle 5: IDLE; a new MdReqE there pulses MdStart.
- Reset mid-operation: assert rst_n=0 in cycle 2 of the above → all outputs 0 immediately. After release with MdReqE=0, the FSM stays IDLE and no MdStart occurs.
- MD_LATENCY=2 boundary: stalls in cycles 0-1 exactly, MdResultSelE in cycle 2.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared encodings for the hazard scheduler: forwarding selects, mul/div FSM states,
// and a helper that computes one operand's forwarding select.
package hazard_pkg;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  localparam logic RESULTSRC_LOAD = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } md_state_t;

  // M outranks W because it holds the younger write to the same register.
  function automatic logic [1:0] fwd_sel(input logic       reg_write_m,
                                         input logic [4:0] rd_m,
                                         input logic       reg_write_w,
                                         input logic [4:0] rd_w,
                                         input logic [4:0] rs);
    if (reg_write_m && (rd_m != 5'd0) && (rd_m == rs)) begin
      return FWD_M;
    end else if (reg_write_w && (rd_w != 5'd0) && (rd_w == rs)) begin
      return FWD_W;
    end
    return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_sched_unit_if.sv
// Hazard scheduler signal bundle: pipeline register fields in, stall/flush/forward/mul-div
// controls out. The slave side is the hazard unit itself.
interface hazard_sched_unit_if;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic       RegWriteM, RegWriteW, ResultSrcE0, PCSrcE, MdReqE;
  logic [1:0] ForwardAE, ForwardBE;
  logic       StallF, StallD, StallE, FlushD, FlushE, FlushM;
  logic       MdStart, MdBusy, MdResultSelE;

  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    output RegWriteM, RegWriteW, ResultSrcE0, PCSrcE, MdReqE,
    input  ForwardAE, ForwardBE, StallF, StallD, StallE, FlushD, FlushE, FlushM,
    input  MdStart, MdBusy, MdResultSelE
  );

  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    input  RegWriteM, RegWriteW, ResultSrcE0, PCSrcE, MdReqE,
    output ForwardAE, ForwardBE, StallF, StallD, StallE, FlushD, FlushE, FlushM,
    output MdStart, MdBusy, MdResultSelE
  );
endinterface

// File: rtl/md_sequencer.sv
// Mul/div sequencer: pulses start, stalls the pipe for MD_LATENCY cycles (issue cycle
// included), then spends one DONE cycle steering the result onto the E bus.
module md_sequencer
  import hazard_pkg::*;
#(
  parameter int unsigned MD_LATENCY = 32,
  localparam int unsigned CNT_W     = $clog2(MD_LATENCY)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic md_req,
  output logic md_start,
  output logic md_stall,
  output logic md_result_sel
);

  localparam logic [CNT_W-1:0] CntLoad = CNT_W'(MD_LATENCY - 2);

  md_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    md_start      = 1'b0;
    md_stall      = 1'b0;
    md_result_sel = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (md_req) begin
          md_start = 1'b1;
          md_stall = 1'b1;
          cnt_d    = CntLoad;
          state_d  = RUN;
        end
      end
      RUN: begin
        md_stall = 1'b1;
        if (cnt_q == '0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      // md_req is deliberately ignored so the finishing op is not re-issued.
      DONE: begin
        md_result_sel = 1'b1;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: rtl/hazard_sched_unit.sv
// Pipeline hazard controller: operand forwarding, load-use stall, branch flush, and
// mul/div pipeline hold via md_sequencer.
module hazard_sched_unit
  import hazard_pkg::*;
#(
  parameter int unsigned MD_LATENCY = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  hazard_sched_unit_if.slave hz
);

  logic active_q;
  logic lw_stall, md_stall, md_req;

  // Holds every output low through reset and the first cycle after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q <= 1'b0;
    end else begin
      active_q <= 1'b1;
    end
  end

  assign md_req = active_q & hz.MdReqE;

  md_sequencer #(
    .MD_LATENCY(MD_LATENCY)
  ) u_md_sequencer (
    .clk          (clk),
    .rst_n        (rst_n),
    .md_req       (md_req),
    .md_start     (hz.MdStart),
    .md_stall     (md_stall),
    .md_result_sel(hz.MdResultSelE)
  );

  assign lw_stall = active_q & (hz.ResultSrcE0 == RESULTSRC_LOAD) & (hz.RdE != 5'd0) &
                    ((hz.RdE == hz.Rs1D) | (hz.RdE == hz.Rs2D));

  assign hz.ForwardAE = active_q ? fwd_sel(hz.RegWriteM, hz.RdM, hz.RegWriteW, hz.RdW, hz.Rs1E)
                                 : FWD_RF;
  assign hz.ForwardBE = active_q ? fwd_sel(hz.RegWriteM, hz.RdM, hz.RegWriteW, hz.RdW, hz.Rs2E)
                                 : FWD_RF;

  assign hz.MdBusy = md_stall;
  assign hz.StallF = lw_stall | md_stall;
  assign hz.StallD = lw_stall | md_stall;
  assign hz.StallE = md_stall;
  // Bubbling M while E is held keeps W from writing the mul/div result twice.
  assign hz.FlushM = md_stall;
  assign hz.FlushD = active_q & hz.PCSrcE;
  assign hz.FlushE = (lw_stall | (active_q & hz.PCSrcE)) & ~md_stall;

endmodule

// File: tb/tb_hazard_sched_unit.sv
// Directed bench for hazard_sched_unit; one DUT at MD_LATENCY=4, one at the MD_LATENCY=2 edge.
module tb_hazard_sched_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  hazard_sched_unit_if if4();
  hazard_sched_unit_if if2();

  hazard_sched_unit #(.MD_LATENCY(4)) dut4 (.clk(clk), .rst_n(rst_n), .hz(if4));
  hazard_sched_unit #(.MD_LATENCY(2)) dut2 (.clk(clk), .rst_n(rst_n), .hz(if2));

  // {FwdA[1:0], FwdB[1:0], StallF, StallD, StallE, FlushD, FlushE, FlushM, MdStart, MdBusy, MdSel}
  logic [12:0] out4, out2;
  assign out4 = {if4.ForwardAE, if4.ForwardBE, if4.StallF, if4.StallD, if4.StallE, if4.FlushD,
                 if4.FlushE, if4.FlushM, if4.MdStart, if4.MdBusy, if4.MdResultSelE};
  assign out2 = {if2.ForwardAE, if2.ForwardBE, if2.StallF, if2.StallD, if2.StallE, if2.FlushD,
                 if2.FlushE, if2.FlushM, if2.MdStart, if2.MdBusy, if2.MdResultSelE};

  localparam logic [12:0] ZERO    = 13'b00_00_000000000;
  localparam logic [12:0] MD_ISS  = 13'b00_00_111001110;
  localparam logic [12:0] MD_RUN  = 13'b00_00_111001010;
  localparam logic [12:0] MD_DONE = 13'b00_00_000000001;

  task automatic check(input string tag, input logic [12:0] obs, input logic [12:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    if4.Rs1D = '0; if4.Rs2D = '0; if4.Rs1E = '0; if4.Rs2E = '0;
    if4.RdE = '0; if4.RdM = '0; if4.RdW = '0;
    if4.RegWriteM = 1'b0; if4.RegWriteW = 1'b0; if4.ResultSrcE0 = 1'b0;
    if4.PCSrcE = 1'b0; if4.MdReqE = 1'b0;
    if2.Rs1D = '0; if2.Rs2D = '0; if2.Rs1E = '0; if2.Rs2E = '0;
    if2.RdE = '0; if2.RdM = '0; if2.RdW = '0;
    if2.RegWriteM = 1'b0; if2.RegWriteW = 1'b0; if2.ResultSrcE0 = 1'b0;
    if2.PCSrcE = 1'b0; if2.MdReqE = 1'b0;
  endtask

  initial begin
    clear_inputs();
    // Forwarding conditions present during reset must stay masked.
    if4.RegWriteM = 1'b1; if4.RdM = 5'd5; if4.Rs1E = 5'd5;
    if4.RegWriteW = 1'b1; if4.RdW = 5'd5;
    tick();
    check("reset_masks_fwd", out4, ZERO);
    check("reset_dut2", out2, ZERO);
    tick();
    rst_n = 1'b1;
    #1;
    check("first_cycle_after_release", out4, ZERO);

    tick();
    check("fwd_a_m_priority", out4, 13'b10_00_000000000);
    if4.RegWriteM = 1'b0;
    #1;
    check("fwd_a_from_w", out4, 13'b01_00_000000000);
    if4.RegWriteM = 1'b1; if4.Rs2E = 5'd5;
    #1;
    check("fwd_ab_from_m", out4, 13'b10_10_000000000);
    if4.RdM = 5'd6; if4.Rs2E = 5'd6;
    #1;
    check("fwd_a_w_b_m", out4, 13'b01_10_000000000);
    if4.RdM = 5'd0; if4.RdW = 5'd0; if4.Rs1E = 5'd0; if4.Rs2E = 5'd0;
    #1;
    check("fwd_x0_never", out4, ZERO);

    clear_inputs();
    if4.ResultSrcE0 = 1'b1; if4.RdE = 5'd7; if4.Rs2D = 5'd7;
    #1;
    check("loaduse_rs2", out4, 13'b00_00_110010000);
    if4.Rs2D = 5'd3; if4.Rs1D = 5'd7;
    #1;
    check("loaduse_rs1", out4, 13'b00_00_110010000);
    if4.ResultSrcE0 = 1'b0;
    #1;
    check("no_load_no_stall", out4, ZERO);
    if4.ResultSrcE0 = 1'b1; if4.RdE = 5'd0; if4.Rs1D = 5'd0; if4.Rs2D = 5'd0;
    #1;
    check("loaduse_x0_never", out4, ZERO);

    clear_inputs();
    if4.PCSrcE = 1'b1;
    #1;
    check("branch_flush", out4, 13'b00_00_000110000);
    if4.ResultSrcE0 = 1'b1; if4.RdE = 5'd9; if4.Rs1D = 5'd9;
    #1;
    check("branch_and_loaduse", out4, 13'b00_00_110110000);

    clear_inputs();
    tick();
    if4.MdReqE = 1'b1;
    #1;
    check("md_c0_issue", out4, MD_ISS);
    tick();
    check("md_c1_run", out4, MD_RUN);
    tick();
    check("md_c2_run", out4, MD_RUN);
    tick();
    check("md_c3_run", out4, MD_RUN);
    tick();
    check("md_c4_done_req_ignored", out4, MD_DONE);
    tick();
    check("md_c5_reissue", out4, MD_ISS);
    tick();
    check("md2_c1_run", out4, MD_RUN);
    tick();
    check("md2_c2_run", out4, MD_RUN);

    rst_n = 1'b0; if4.MdReqE = 1'b0;
    #1;
    check("reset_mid_run_immediate", out4, ZERO);
    tick();
    check("reset_mid_run_held", out4, ZERO);
    rst_n = 1'b1;
    #1;
    check("release_first_cycle", out4, ZERO);
    tick();
    check("after_reset_idle_1", out4, ZERO);
    tick();
    check("after_reset_idle_2", out4, ZERO);
    if4.MdReqE = 1'b1;
    #1;
    check("after_reset_fresh_issue", out4, MD_ISS);
    tick();
    if4.MdReqE = 1'b0;
    #1;
    check("after_reset_run", out4, MD_RUN);

    tick();
    if2.MdReqE = 1'b1;
    #1;
    check("lat2_c0_issue", out2, MD_ISS);
    tick();
    check("lat2_c1_run", out2, MD_RUN);
    tick();
    check("lat2_c2_done", out2, MD_DONE);
    if2.MdReqE = 1'b0;
    tick();
    check("lat2_c3_idle", out2, ZERO);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
